// File: rtl/jtag_apb_cmd_seq_if.sv
// Bundle of the JTAG command/response handshake and the APB3 master bus for jtag_apb_cmd_seq.
// Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready; cmd_ready is high only while idle,
// and resp_done/resp_data stay stable from completion until the next accepted command.
interface jtag_apb_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [87:0] cmd_data;
  logic [48:0] resp_data;
  logic        resp_done;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  dbg_state;

  modport master (
    input  cmd_valid, cmd_data, prdata, pready, pslverr,
    output cmd_ready, resp_data, resp_done, paddr, psel, penable, pwrite, pwdata, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_data, prdata, pready, pslverr,
    input  cmd_ready, resp_data, resp_done, paddr, psel, penable, pwrite, pwdata, dbg_state
  );
endinterface

// File: rtl/jtag_apb_cmd_seq.sv
// Turns one captured 88-bit JTAG APB command into one or two APB3 beats and builds the 49-bit response.
// Optional ACCESS-phase timeout is enabled by defining JTAG_APB_TIMEOUT_EN.
module jtag_apb_cmd_seq #(
  parameter int ADDR_INC       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 rstn,
  jtag_apb_cmd_seq_if.master  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam logic [31:0] INC = 32'(ADDR_INC);

  state_t      state_q, state_n;
  logic [31:0] addr_q;
  logic        d32_q, wr_q, rd_q, beat_q;
  logic [47:0] data_q, data_n;
  logic        resp_done_q;
  logic [48:0] resp_data_q;
  logic        accept, legal, cmd_rd, cmd_wr, last_beat, busy, tmo_hit;

  // Reserved command bits carry no meaning.
  wire unused_rsvd = ^bus.cmd_data[55:51];

  assign cmd_rd    = bus.cmd_data[48];
  assign cmd_wr    = bus.cmd_data[49];
  assign accept    = (state_q == IDLE) && bus.cmd_valid;
  assign legal     = cmd_rd ^ cmd_wr;
  assign last_beat = beat_q | d32_q;
  assign busy      = (state_q != IDLE);

`ifdef JTAG_APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state_q == ACCESS) && !bus.pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  assign tmo_hit = (state_q == ACCESS) && !bus.pready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  wire unused_tmo = (TIMEOUT_CYCLES > 1);
`endif

  always_comb begin
    data_n = data_q;
    if (rd_q && beat_q) begin
      data_n[47:32] = bus.prdata[15:0];
    end else if (rd_q) begin
      data_n[31:0] = bus.prdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (accept && legal) state_n = SETUP;
      end
      SETUP: begin
        state_n = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_n = (bus.pslverr || last_beat) ? IDLE : SETUP;
        end else if (tmo_hit) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      d32_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      beat_q      <= 1'b0;
      data_q      <= '0;
      resp_done_q <= 1'b0;
      resp_data_q <= '0;
    end else if (accept) begin
      addr_q      <= bus.cmd_data[87:56];
      d32_q       <= bus.cmd_data[50];
      wr_q        <= cmd_wr;
      rd_q        <= cmd_rd;
      beat_q      <= 1'b0;
      // Reads start from zero so uncaptured bits read back as 0.
      data_q      <= (cmd_wr && !cmd_rd) ? bus.cmd_data[47:0] : 48'h0;
      resp_done_q <= !legal;
      resp_data_q <= {cmd_rd & cmd_wr, 48'h0};
    end else if (state_q == ACCESS) begin
      if (bus.pready) begin
        data_q <= data_n;
        if (bus.pslverr || last_beat) begin
          resp_done_q <= 1'b1;
          resp_data_q <= {bus.pslverr, data_n};
        end else begin
          beat_q <= 1'b1;
        end
      end else if (tmo_hit) begin
        resp_done_q <= 1'b1;
        resp_data_q <= {1'b1, data_q};
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.resp_done = resp_done_q;
  assign bus.resp_data = resp_data_q;
  assign bus.psel      = busy;
  assign bus.penable   = (state_q == ACCESS);
  assign bus.pwrite    = busy & wr_q;
  assign bus.paddr     = !busy ? 32'h0 : (beat_q ? addr_q + INC : addr_q);
  assign bus.pwdata    = !(busy && wr_q) ? 32'h0 : (beat_q ? {16'h0, data_q[47:32]} : data_q[31:0]);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_jtag_apb_cmd_seq.sv
// Bench for jtag_apb_cmd_seq: directed vector table, hand-written corner sequences and random commands
// checked against a transaction-level reference model.
module tb_jtag_apb_cmd_seq;
  localparam int TMO  = 8;
  localparam int AINC = 4;

  logic clk;
  logic rstn;
  jtag_apb_cmd_seq_if bus();

  jtag_apb_cmd_seq #(.ADDR_INC(AINC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Completed APB beats as {paddr, pwrite, pwdata}.
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];

  int          s_waits[2];
  logic [31:0] s_rdata[2];
  bit          s_err[2];
  int          s_beat;
  int          s_wcnt;

  typedef struct {
    string       name;
    logic [87:0] cmd;
    int          w0, w1;
    logic [31:0] r0, r1;
    bit          e0, e1;
    logic [48:0] resp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [87:0] mk(input logic [31:0] addr, input logic [4:0] rsvd, input bit d32,
                                     input bit wr, input bit rd, input logic [47:0] data);
    return {addr, rsvd, d32, wr, rd, data};
  endfunction

  // APB slave: programmable wait states, read data and error per beat; logs each completed beat.
  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      int bi;
      bi = (s_beat > 1) ? 1 : s_beat;
      if (s_wcnt < s_waits[bi]) begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        s_wcnt++;
      end else begin
        bus.pready  = 1'b1;
        bus.prdata  = s_rdata[bi];
        bus.pslverr = s_err[bi];
        obs_q.push_back({bus.paddr, bus.pwrite, bus.pwdata});
        s_beat++;
        s_wcnt = 0;
      end
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0;
    end
  end

  // Transaction-level reference: expected beats, response word and cycles from acceptance to resp_done.
  task automatic model(input logic [87:0] cmd, input int w0, input int w1, input logic [31:0] r0,
                       input logic [31:0] r1, input bit e0, input bit e1,
                       output logic [48:0] resp, output int lat);
    logic [31:0] addr;
    logic [47:0] wdat, rdat;
    bit d32, wr, rd, err;
    int waits[2];
    logic [31:0] rds[2];
    bit errs[2];
    addr = cmd[87:56]; d32 = cmd[50]; wr = cmd[49]; rd = cmd[48]; wdat = cmd[47:0];
    waits[0] = w0; waits[1] = w1; rds[0] = r0; rds[1] = r1; errs[0] = e0; errs[1] = e1;
    rdat = 48'h0;
    err  = 1'b0;
    lat  = 1;
    if (rd == wr) begin
      resp = {rd & wr, 48'h0};
      return;
    end
    for (int b = 0; b < (d32 ? 1 : 2); b++) begin
`ifdef JTAG_APB_TIMEOUT_EN
      if (waits[b] >= TMO) begin
        lat += 1 + TMO;
        err = 1'b1;
        break;
      end
`endif
      lat += 2 + waits[b];
      exp_q.push_back({addr + 32'(AINC * b), wr,
                       wr ? ((b == 0) ? wdat[31:0] : {16'h0, wdat[47:32]}) : 32'h0});
      if (b == 0) rdat[31:0] = rds[0];
      else        rdat[47:32] = rds[1][15:0];
      if (errs[b]) begin
        err = 1'b1;
        break;
      end
    end
    resp = {err, wr ? wdat : rdat};
  endtask

  task automatic run_cmd(input string name, input logic [87:0] cmd, input int w0, input int w1,
                         input logic [31:0] r0, input logic [31:0] r1, input bit e0, input bit e1,
                         input bit has_exp, input logic [48:0] t_resp, input int t_lat, input bit intrude);
    logic [48:0] m_resp, want_resp;
    int m_lat, want_lat, lat;
    bit done;
    exp_q.delete();
    obs_q.delete();
    s_waits[0] = w0; s_waits[1] = w1;
    s_rdata[0] = r0; s_rdata[1] = r1;
    s_err[0]   = e0; s_err[1]   = e1;
    s_beat = 0;
    s_wcnt = 0;
    model(cmd, w0, w1, r0, r1, e0, e1, m_resp, m_lat);
    want_resp = has_exp ? t_resp : m_resp;
    want_lat  = has_exp ? t_lat : m_lat;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = cmd;
    @(posedge clk);
    lat  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.cmd_valid = 1'b0;
      if (intrude && lat == 3) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = mk(32'h5000_0000, 5'h0, 1'b1, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF);
        check({name, "_busy_ready"}, 96'(bus.cmd_ready), 96'(0));
      end
      if (intrude && lat == 4) bus.cmd_valid = 1'b0;
      if (bus.resp_done) done = 1'b1;
    end
    if (!done) check({name, "_resp_timeout"}, 96'(0), 96'(1));
    check({name, "_latency"}, 96'(lat), 96'(want_lat));
    check({name, "_resp"}, 96'(bus.resp_data), 96'(want_resp));
    if (intrude) begin
      repeat (3) @(negedge clk);
      check({name, "_resp_held"}, 96'(bus.resp_data), 96'(want_resp));
      check({name, "_done_held"}, 96'(bus.resp_done), 96'(1));
      check({name, "_idle_psel"}, 96'(bus.psel), 96'(0));
    end
    check({name, "_beats"}, 96'(obs_q.size()), 96'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check({name, "_beat"}, 96'(obs_q.pop_front()), 96'(exp_q.pop_front()));
    end
  endtask

  initial begin
    logic [48:0] dummy_resp;
    rstn          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    s_beat = 0; s_wcnt = 0;
    s_waits[0] = 0; s_waits[1] = 0;
    s_rdata[0] = 0; s_rdata[1] = 0;
    s_err[0] = 0; s_err[1] = 0;

    vecs[0] = '{"wr32", mk(32'h4000_1000, 5'h0, 1, 1, 0, 48'h0000_1234_5678), 0, 0, 32'h0, 32'h0, 0, 0,
                {1'b0, 48'h0000_1234_5678}, 3};
    vecs[1] = '{"rd48_wait", mk(32'h4000_2000, 5'h0, 0, 0, 1, 48'h0), 0, 2, 32'hAABB_CCDD, 32'h1111_EEFF, 0, 0,
                {1'b0, 48'hEEFF_AABB_CCDD}, 7};
    vecs[2] = '{"wr48_err0", mk(32'h4000_3000, 5'h0, 0, 1, 0, 48'hABCD_0123_4567), 0, 0, 32'h0, 32'h0, 1, 0,
                {1'b1, 48'hABCD_0123_4567}, 3};
    vecs[3] = '{"illegal", mk(32'h4000_4000, 5'h0, 0, 1, 1, 48'h1234_5678_9ABC), 0, 0, 32'h0, 32'h0, 0, 0,
                {1'b1, 48'h0}, 1};
    vecs[4] = '{"nop", mk(32'h4000_5000, 5'h0, 0, 0, 0, 48'h1234_5678_9ABC), 0, 0, 32'h0, 32'h0, 0, 0,
                {1'b0, 48'h0}, 1};
    vecs[5] = '{"rd48_wrap", mk(32'hFFFF_FFFC, 5'h0, 0, 0, 1, 48'h0), 0, 0, 32'h0102_0304, 32'h0000_5566, 0, 0,
                {1'b0, 48'h5566_0102_0304}, 5};
    vecs[6] = '{"wr48", mk(32'h0000_0010, 5'h0, 0, 1, 0, 48'h9876_5432_10FE), 0, 0, 32'h0, 32'h0, 0, 0,
                {1'b0, 48'h9876_5432_10FE}, 5};
    vecs[7] = '{"rd48_err1", mk(32'h0000_0020, 5'h0, 0, 0, 1, 48'h0), 1, 0, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1,
                {1'b1, 48'h5678_DEAD_BEEF}, 6};
    vecs[8] = '{"rd32", mk(32'h0000_0030, 5'h0, 1, 0, 1, 48'h0), 0, 0, 32'hCAFE_F00D, 32'h0, 0, 0,
                {1'b0, 48'h0000_CAFE_F00D}, 3};
    vecs[9] = '{"rd32_rsvd", mk(32'h0000_0040, 5'h1F, 1, 0, 1, 48'hFFFF_FFFF_FFFF), 1, 0, 32'h8765_4321, 32'h0, 0, 0,
                {1'b0, 48'h0000_8765_4321}, 4};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 96'(bus.cmd_ready), 96'(1));
    check("rst_psel", 96'(bus.psel), 96'(0));
    check("rst_penable", 96'(bus.penable), 96'(0));
    check("rst_resp_done", 96'(bus.resp_done), 96'(0));
    check("rst_resp_data", 96'(bus.resp_data), 96'(0));
    check("rst_apb_out", 96'({bus.paddr, bus.pwdata, bus.pwrite}), 96'(0));
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].name, vecs[i].cmd, vecs[i].w0, vecs[i].w1, vecs[i].r0, vecs[i].r1,
              vecs[i].e0, vecs[i].e1, 1'b1, vecs[i].resp, vecs[i].lat, 1'b0);
    end

    // A command offered while busy must be dropped without disturbing the transaction.
    run_cmd("busy_ignore", mk(32'h6000_0000, 5'h0, 0, 0, 1, 48'h0), 4, 1, 32'h1357_9BDF, 32'h0000_2468, 0, 0,
            1'b1, {1'b0, 48'h2468_1357_9BDF}, 10, 1'b1);

    // Reset while a beat is stalled in ACCESS.
    exp_q.delete();
    obs_q.delete();
    s_waits[0] = 10; s_beat = 0; s_wcnt = 0;
    s_err[0] = 0; s_err[1] = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(32'h7000_0000, 5'h0, 1, 1, 0, 48'h0000_AAAA_5555);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_access", 96'({bus.psel, bus.penable}), 96'(3));
    rstn = 1'b0;
    #1;
    check("midrst_psel_penable", 96'({bus.psel, bus.penable}), 96'(0));
    check("midrst_resp_done", 96'(bus.resp_done), 96'(0));
    check("midrst_cmd_ready", 96'(bus.cmd_ready), 96'(1));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_no_beat", 96'(obs_q.size()), 96'(0));

`ifdef JTAG_APB_TIMEOUT_EN
    run_cmd("timeout", mk(32'h8000_0000, 5'h0, 1, 0, 1, 48'h0), 1000, 0, 32'h0, 32'h0, 0, 0,
            1'b1, {1'b1, 48'h0}, 2 + TMO, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [87:0] cmd;
      logic [47:0] d;
      int k;
      bit rd, wr;
      k = $urandom_range(0, 9);
      rd = (k == 0) || (k >= 2 && k <= 5);
      wr = (k == 0) || (k >= 6);
      d  = {16'($urandom), 32'($urandom)};
      cmd = mk(32'($urandom), 5'($urandom), 1'($urandom), wr, rd, d);
      run_cmd("rand", cmd, $urandom_range(0, 3), $urandom_range(0, 3), 32'($urandom), 32'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0, dummy_resp, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_apb_cmd_seq.md
Name: jtag_apb_cmd_seq

Overview:
- Sequences one captured JTAG APB command (88-bit command word) into an APB3 master transaction.
- Returns a 49-bit response word {suberr, data[47:0]} for the JTAG DR capture path.
- Sits between the JTAG DR shift/update logic and the debug APB fabric, in the same clock domain as the APB.
- A 48-bit access is split into two 32-bit APB beats; a 32-bit access (d32bit=1) uses one beat.

Parameters:
- ADDR_INC, 4, byte offset added to addr for the second beat of a 48-bit access.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit when JTAG_APB_TIMEOUT_EN is defined (must be ≥2).

Ports:
- clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command word valid (single-cycle pulse or level).
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready.
- cmd_data  in  88  {addr[31:0], rsvd[4:0], d32bit, write, read, data[47:0]}.
- resp_data  out  49  {suberr, data[47:0]}.
- resp_done  out  1  high from command completion until the next command is accepted.
- paddr  out  32  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (async, rstn low): state IDLE, all outputs 0 except cmd_ready=1. A transaction in flight is abandoned immediately: psel/penable drop with no completion.
- States: IDLE, SETUP, ACCESS.
- Beat counter: 1 bit, beat 0 or beat 1.
- Acceptance, cycle t in IDLE with cmd_valid=1:
  - Latch addr, d32bit, write, read, data.
  - Clear resp_done and resp_data.
  - cmd_ready goes 0 from t+1.
- Illegal and empty commands (decoded at acceptance, no APB activity, stay in IDLE):
  - read=1 and write=1: resp_done=1 at t+1, suberr=1, data=0.
  - read=0 and write=0: resp_done=1 at t+1, suberr=0, data=0 (nop).
- Legal command: IDLE→SETUP at t+1.
- SETUP: psel=1, penable=0, pwrite=write.
  - paddr = addr for beat 0; addr+ADDR_INC for beat 1 (mod 2^32, wraps 0xFFFFFFFC→0x00000000).
  - pwdata = data[31:0] for beat 0; {16'h0, data[47:32]} for beat 1; 0 on reads.
  - Next state ACCESS, unconditionally.
- ACCESS: psel=1, penable=1, paddr/pwdata/pwrite held stable. Stay while pready=0.
- On pready=1:
  - Read, beat 0: capture data[31:0] ← prdata.
  - Read, beat 1: capture data[47:32] ← prdata[15:0].
  - If pslverr=1: suberr ← 1, go to IDLE. Beat 1 is skipped; data holds what was captured so far.
  - Else if beat 0 and d32bit=0: beat ← 1, go to SETUP.
  - Else: go to IDLE.
- On entry to IDLE from ACCESS:
  - psel=penable=0.
  - resp_done=1.
  - resp_data = {suberr, data}. Reads: d32bit=1 gives data[47:32]=0. Writes return the written data with suberr.
- Latency, zero wait states (accept at t):
  - 32-bit: resp_done at t+3.
  - 48-bit: resp_done at t+5.
  - Each pready=0 cycle adds 1.
- Handshake: cmd_valid while cmd_ready=0 is ignored; no queuing. Command and response are never overwritten mid-transaction.
- rsvd bits are ignored.

Optional Feature:
- JTAG_APB_TIMEOUT_EN defined:
  - A counter resets on each SETUP and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES: drop psel/penable, go to IDLE, resp_done=1, suberr=1. data holds what was captured so far; remaining beats are skipped.
- Not defined: no counter logic; ACCESS waits indefinitely for pready.

Test Plan:
- 32-bit write: addr=0x40001000, d32bit=1, write=1, data=0x0000_1234_5678, pready=1 → one beat, paddr=0x40001000, pwdata=0x12345678, resp_done at t+3, resp_data={0,0x000012345678}.
- 48-bit read: addr=0x40002000, d32bit=0, prdata=0xAABBCCDD then 0x1111EEFF, 2 wait states on beat 1 → paddr=0x40002000 then 0x40002004, resp_data={0,0xEEFFAABBCCDD}, resp_done at t+7.
- Error abort: 48-bit write, pslverr=1 on beat 0 → only one APB access, resp_done at t+3, suberr=1.
- Illegal and nop: read=write=1 → suberr=1, no psel, resp_done at t+1. read=write=0 → suberr=0, data=0, resp_done at t+1.
- Boundary: addr=0xFFFFFFFC, 48-bit read → beat-1 paddr=0x00000000. cmd_valid asserted during ACCESS → ignored, response unchanged.
- Reset mid-ACCESS: pull rstn low → psel/penable/resp_done 0 same cycle, cmd_ready=1. With JTAG_APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 → exit after 8 ACCESS cycles with suberr=1.
